aes_ctrl_param: RTL and testbench
=================================

Name: aes_ctrl_param

Overview:
Parametrised next-generation main controller for the AES accelerator.
- Sequences key-change and encrypt/decrypt jobs between the AHB-lite interface, GenKey and AESctr.
- Supports a configurable block size in bus words, handshaked word transfers, back-to-back streaming, a watchdog timeout with an error state, and an optional prefetch mode.

Parameters:
WORDS, 4, bus words per 128-bit block/key transfer (2..16)
TIMEOUT, 64, max cycles allowed in CHG_KEY or WAIT before error (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  job request from interface; held high for streaming
data_received  in  1  interface has a valid input word this cycle
tx_ready  in  1  interface can accept an output word this cycle
data_type  in  1  1 = key load, 0 = data; sampled in IDLE with start
enc_dec  in  1  0 = encrypt, 1 = decrypt; sampled in IDLE with start
chg_key_done  in  1  GenKey finished storing key
enc_done  in  1  AESctr finished current block
clr_err  in  1  clears ERROR state
opt_mode  out  1  latched enc_dec for the job
load_key  out  1  level, high throughout CHG_KEY
aes_enable  out  1  one-cycle pulse starting AESctr
ahb_mode  out  1  0 = interface inputs, 1 = interface outputs
ahb_shift_en  out  1  interface shift strobe for the current word
done_chg_key  out  1  one-cycle pulse on key-change completion
busy  out  1  high in every state except IDLE and ERROR
error  out  1  high in ERROR
word_idx  out  $clog2(WORDS)  current word index within the block

Behaviour:
- Reset (rst high at posedge) has priority over all other events, including mid-job.
- Reset values: state IDLE, all outputs 0, all counters 0.
- States: IDLE, FETCH, CHG_KEY, ENC, WAIT, WRITE, ERROR.
- Transitions out of IDLE:
  - start=1 -> FETCH.
  - Latch data_type into an internal job type and enc_dec into opt_mode.
  - word_idx <= 0.
- FETCH:
  - ahb_mode=0; ahb_shift_en = data_received (combinational).
  - Each accepted word increments word_idx.
  - On the accepted word with word_idx == WORDS-1: word_idx <= 0, then -> CHG_KEY if job type is key, else -> ENC.
  - No data_received: hold; no timeout.
- CHG_KEY:
  - load_key=1; timeout counter runs.
  - chg_key_done=1 -> IDLE, with done_chg_key pulsed for the one cycle of that transition.
  - Counter reaching TIMEOUT -> ERROR.
  - If both happen in the same cycle, chg_key_done wins.
- ENC: exactly one cycle; aes_enable=1; then -> WAIT.
- WAIT:
  - Timeout counter runs.
  - enc_done=1 -> WRITE; counter reaching TIMEOUT -> ERROR. enc_done wins ties.
  - enc_done is sampled only in WAIT.
- WRITE:
  - ahb_mode=1; ahb_shift_en = tx_ready.
  - word_idx increments on each strobe.
  - After the last word: if start=1 -> FETCH (streaming, same job type and opt_mode, no re-latch); else -> IDLE.
- ERROR:
  - error=1, busy=0, all strobes 0.
  - clr_err=1 -> IDLE, with counters cleared.
- Timeout counter: cleared on every state entry; saturates at TIMEOUT; width $clog2(TIMEOUT+1).
- Input stability: data_type and enc_dec changes outside IDLE are ignored.
- Glitch-free requirement: aes_enable and done_chg_key are never high for two consecutive cycles.

Optional Feature:
Macro: AES_CTRL_PREFETCH_EN
- Defined:
  - In WAIT, the controller also acts as FETCH for the next block: ahb_mode=0, ahb_shift_en=data_received.
  - A separate prefetch counter counts up to WORDS words, then stops accepting.
  - The timeout still applies.
  - At the end of WRITE with start=1: prefetch count == WORDS -> ENC directly; otherwise -> FETCH, resuming at word_idx = prefetch count.
  - The prefetch counter clears on entry to ENC.
- Undefined: no fetching in WAIT (ahb_shift_en=0 in WAIT), and no prefetch counter logic is synthesised.

Test Plan:
1. Key load, WORDS=4: start=1 with data_type=1, 4 words with data_received high each cycle, chg_key_done 3 cycles later -> load_key high 3 cycles, done_chg_key single pulse, back in IDLE, busy=0.
2. Encrypt with stalls: enc_dec=0 job, data_received toggling 1,0,1,0,... -> word_idx steps 0..3 only on accepted words; aes_enable single pulse after the 4th word; opt_mode=0.
3. Decrypt streaming: start held high, enc_done 10 cycles after each ENC, tx_ready always high -> two blocks processed; opt_mode=1 throughout; FETCH re-entered directly after WRITE.
4. Watchdog: enc_done never asserted, TIMEOUT=64 -> ERROR entered exactly 64 cycles after WAIT entry; error=1. Then clr_err pulse -> IDLE.
5. Reset mid-WRITE (word_idx=2): rst high one cycle -> next cycle state IDLE, all outputs 0, word_idx=0.
6. With AES_CTRL_PREFETCH_EN: 4 words arrive during WAIT -> after WRITE, ENC entered directly; aes_enable pulses within 1 cycle of the last output word.

Source files
------------

// File: rtl/aes_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : aes_ctrl_param
// Purpose  : Main controller for the AES accelerator. It sequences key-change
//            and encrypt/decrypt jobs between the AHB-lite interface, GenKey
//            and AESctr. Blocks and keys are WORDS bus words long. Word
//            transfers are handshaked, jobs can stream back-to-back, and a
//            watchdog forces an ERROR state.
// Option   : `define AES_CTRL_PREFETCH_EN lets the controller collect the next
//            block's input words while it waits for AESctr.
// Ports    : clk, rst (sync, active-high)
//            start, data_type, enc_dec   - job request and job attributes
//            data_received, tx_ready     - interface word handshakes
//            chg_key_done, enc_done      - GenKey / AESctr completion
//            clr_err                     - leave ERROR
//            opt_mode, load_key, aes_enable, ahb_mode, ahb_shift_en,
//            done_chg_key, busy, error, word_idx - control / status outputs
// Revision : 1.0 - initial release
// ============================================================================
module aes_ctrl_param #(
    parameter int WORDS   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       data_received,
    input  logic                       tx_ready,
    input  logic                       data_type,
    input  logic                       enc_dec,
    input  logic                       chg_key_done,
    input  logic                       enc_done,
    input  logic                       clr_err,
    output logic                       opt_mode,
    output logic                       load_key,
    output logic                       aes_enable,
    output logic                       ahb_mode,
    output logic                       ahb_shift_en,
    output logic                       done_chg_key,
    output logic                       busy,
    output logic                       error,
    output logic [$clog2(WORDS)-1:0]   word_idx
);

    localparam int c_IDX_W = $clog2(WORDS);
    localparam int c_TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WORDS - 1);
    // The watchdog fires on the cycle whose count is TIMEOUT-1, so the
    // controller sits in a guarded state for exactly TIMEOUT cycles.
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX  = c_TMO_W'(TIMEOUT);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_FETCH   = 3'd1;
    localparam logic [2:0] c_ST_CHG_KEY = 3'd2;
    localparam logic [2:0] c_ST_ENC     = 3'd3;
    localparam logic [2:0] c_ST_WAIT    = 3'd4;
    localparam logic [2:0] c_ST_WRITE   = 3'd5;
    localparam logic [2:0] c_ST_ERROR   = 3'd6;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_word_idx;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic               r_job_key;
    logic               w_job_key_nxt;
    logic               r_opt_mode;
    logic               w_opt_nxt;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               w_tmo_run;
    logic               w_tmo_hit;

`ifdef AES_CTRL_PREFETCH_EN
    localparam int c_PF_W = $clog2(WORDS + 1);
    localparam logic [c_PF_W-1:0] c_PF_FULL = c_PF_W'(WORDS);

    logic [c_PF_W-1:0] r_pf_cnt;
    logic              w_pf_take;
`endif

    assign w_tmo_run = (r_state == c_ST_CHG_KEY) || (r_state == c_ST_WAIT);
    assign w_tmo_hit = w_tmo_run && (r_tmo_cnt == c_TMO_LAST);

    assign word_idx  = r_word_idx;
    assign opt_mode  = r_opt_mode;

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_word_idx;
        w_job_key_nxt = r_job_key;
        w_opt_nxt     = r_opt_mode;
        load_key      = 1'b0;
        aes_enable    = 1'b0;
        ahb_mode      = 1'b0;
        ahb_shift_en  = 1'b0;
        done_chg_key  = 1'b0;
        busy          = 1'b1;
        error         = 1'b0;
`ifdef AES_CTRL_PREFETCH_EN
        w_pf_take     = 1'b0;
`endif
        case (r_state)
            c_ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt   = c_ST_FETCH;
                    w_job_key_nxt = data_type;
                    w_opt_nxt     = enc_dec;
                    w_idx_nxt     = '0;
                end
            end
            c_ST_FETCH: begin
                ahb_shift_en = data_received;
                if (data_received) begin
                    if (r_word_idx == c_IDX_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = r_job_key ? c_ST_CHG_KEY : c_ST_ENC;
                    end else begin
                        w_idx_nxt = r_word_idx + 1'b1;
                    end
                end
            end
            c_ST_CHG_KEY: begin
                load_key = 1'b1;
                // Completion takes precedence over a same-cycle watchdog hit.
                if (chg_key_done) begin
                    done_chg_key = 1'b1;
                    w_state_nxt  = c_ST_IDLE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_ST_ERROR;
                end
            end
            c_ST_ENC: begin
                aes_enable  = 1'b1;
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
`ifdef AES_CTRL_PREFETCH_EN
                // Collect up to one full block for the next job while AESctr
                // runs; once WORDS words are held the interface is stalled.
                w_pf_take    = data_received && (r_pf_cnt != c_PF_FULL);
                ahb_shift_en = w_pf_take;
`endif
                if (enc_done) begin
                    w_state_nxt = c_ST_WRITE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_ST_ERROR;
                end
            end
            c_ST_WRITE: begin
                ahb_mode     = 1'b1;
                ahb_shift_en = tx_ready;
                if (tx_ready) begin
                    if (r_word_idx == c_IDX_LAST) begin
                        w_idx_nxt = '0;
                        if (start) begin
`ifdef AES_CTRL_PREFETCH_EN
                            if (r_pf_cnt == c_PF_FULL) begin
                                w_state_nxt = c_ST_ENC;
                            end else begin
                                // Resume fetching after the words already held.
                                w_state_nxt = c_ST_FETCH;
                                w_idx_nxt   = r_pf_cnt[c_IDX_W-1:0];
                            end
`else
                            w_state_nxt = c_ST_FETCH;
`endif
                        end else begin
                            w_state_nxt = c_ST_IDLE;
                        end
                    end else begin
                        w_idx_nxt = r_word_idx + 1'b1;
                    end
                end
            end
            c_ST_ERROR: begin
                busy  = 1'b0;
                error = 1'b1;
                if (clr_err) begin
                    w_state_nxt = c_ST_IDLE;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = c_ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_word_idx <= '0;
            r_job_key  <= 1'b0;
            r_opt_mode <= 1'b0;
            r_tmo_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_idx <= w_idx_nxt;
            r_job_key  <= w_job_key_nxt;
            r_opt_mode <= w_opt_nxt;
            // Restart the watchdog on every state change.
            if (w_state_nxt != r_state) begin
                r_tmo_cnt <= '0;
            end else if (w_tmo_run && (r_tmo_cnt != c_TMO_MAX)) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

`ifdef AES_CTRL_PREFETCH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pf_cnt <= '0;
        end else if ((w_state_nxt == c_ST_ENC) || (r_state == c_ST_IDLE) ||
                     (r_state == c_ST_ERROR)) begin
            r_pf_cnt <= '0;
        end else if (w_pf_take) begin
            r_pf_cnt <= r_pf_cnt + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_ctrl_param
// Purpose  : Directed self-checking bench for aes_ctrl_param (WORDS=4,
//            TIMEOUT=64). Covers reset, key load, stalled encrypt, decrypt
//            streaming, watchdog/ERROR recovery and reset mid-WRITE; the
//            prefetch scenario is included when AES_CTRL_PREFETCH_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_ctrl_param;

    localparam int c_WORDS   = 4;
    localparam int c_TIMEOUT = 64;
`ifdef AES_CTRL_PREFETCH_EN
    localparam int c_PF_EXP  = 1;
`else
    localparam int c_PF_EXP  = 0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic       data_received;
    logic       tx_ready;
    logic       data_type;
    logic       enc_dec;
    logic       chg_key_done;
    logic       enc_done;
    logic       clr_err;
    logic       opt_mode;
    logic       load_key;
    logic       aes_enable;
    logic       ahb_mode;
    logic       ahb_shift_en;
    logic       done_chg_key;
    logic       busy;
    logic       error;
    logic [1:0] word_idx;

    int n_checks = 0;
    int n_fail   = 0;

    aes_ctrl_param #(
        .WORDS   (c_WORDS),
        .TIMEOUT (c_TIMEOUT)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .data_received (data_received),
        .tx_ready      (tx_ready),
        .data_type     (data_type),
        .enc_dec       (enc_dec),
        .chg_key_done  (chg_key_done),
        .enc_done      (enc_done),
        .clr_err       (clr_err),
        .opt_mode      (opt_mode),
        .load_key      (load_key),
        .aes_enable    (aes_enable),
        .ahb_mode      (ahb_mode),
        .ahb_shift_en  (ahb_shift_en),
        .done_chg_key  (done_chg_key),
        .busy          (busy),
        .error         (error),
        .word_idx      (word_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed one block of words in FETCH, one per cycle.
    task automatic fetch_words();
        data_received = 1'b1;
        repeat (c_WORDS) step();
        data_received = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},     busy,         0);
        chk({tag, "_error"},    error,        0);
        chk({tag, "_idx"},      word_idx,     0);
        chk({tag, "_opt"},      opt_mode,     0);
        chk({tag, "_load_key"}, load_key,     0);
        chk({tag, "_aes_en"},   aes_enable,   0);
        chk({tag, "_ahb_mode"}, ahb_mode,     0);
        chk({tag, "_shift"},    ahb_shift_en, 0);
        chk({tag, "_done_key"}, done_chg_key, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data_received = 1'b0; tx_ready = 1'b0;
        data_type = 1'b0; enc_dec = 1'b0; chg_key_done = 1'b0;
        enc_done = 1'b0; clr_err = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        chk_all_zero("reset");

        // ---- 1: key load, chg_key_done on the 3rd CHG_KEY cycle ----
        start = 1'b1; data_type = 1'b1; enc_dec = 1'b0;
        step();
        start = 1'b0;
        data_received = 1'b1;
        #1;
        chk("key_fetch_busy", busy, 1);
        chk("key_fetch_shift", ahb_shift_en, 1);
        for (int i = 0; i < c_WORDS; i++) begin
            chk("key_fetch_idx", word_idx, i);
            step();
        end
        data_received = 1'b0;
        #1;
        chk("key_load_c1", load_key, 1);
        chk("key_load_idx", word_idx, 0);
        chk("key_no_done_c1", done_chg_key, 0);
        step();
        chk("key_load_c2", load_key, 1);
        step();
        chk_key_done_phase();

        // ---- 2: encrypt with data_received toggling ----
        start = 1'b1; data_type = 1'b0; enc_dec = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 2 * c_WORDS - 1; k++) begin
            data_received = (k % 2 == 0);
            #1;
            chk("enc_stall_idx", word_idx, (k + 1) / 2);
            chk("enc_stall_shift", ahb_shift_en, (k % 2 == 0) ? 1 : 0);
            step();
        end
        data_received = 1'b0;
        #1;
        chk("enc_aes_pulse", aes_enable, 1);
        chk("enc_opt", opt_mode, 0);
        step();
        chk("enc_aes_single", aes_enable, 0);
        chk("enc_wait_busy", busy, 1);
        enc_done = 1'b1;
        step();
        enc_done = 1'b0;
        tx_ready = 1'b1;
        #1;
        chk("enc_write_mode", ahb_mode, 1);
        chk("enc_write_shift", ahb_shift_en, 1);
        repeat (c_WORDS) step();
        tx_ready = 1'b0;
        #1;
        chk("enc_back_idle", busy, 0);

        // ---- 3: decrypt streaming, two blocks ----
        start = 1'b1; data_type = 1'b0; enc_dec = 1'b1;
        step();
        enc_dec = 1'b0;              // must be ignored outside IDLE
        for (int b = 0; b < 2; b++) begin
            fetch_words();
            #1;
            chk("dec_aes_pulse", aes_enable, 1);
            chk("dec_opt", opt_mode, 1);
            step();
            chk("dec_aes_single", aes_enable, 0);
            repeat (8) step();
            enc_done = 1'b1;
            step();
            enc_done = 1'b0;
            tx_ready = 1'b1;
            if (b == 1) start = 1'b0;
            #1;
            chk("dec_write_mode", ahb_mode, 1);
            for (int i = 0; i < c_WORDS; i++) begin
                chk("dec_write_idx", word_idx, i);
                step();
            end
            tx_ready = 1'b0;
            #1;
            if (b == 0) begin
                chk("dec_stream_busy", busy, 1);
                chk("dec_stream_fetch", ahb_mode, 0);
                chk("dec_stream_idx", word_idx, 0);
                chk("dec_stream_opt", opt_mode, 1);
            end else begin
                chk("dec_end_idle", busy, 0);
            end
        end

        // ---- 4: watchdog in WAIT, then clr_err ----
        start = 1'b1; data_type = 1'b0; enc_dec = 1'b0;
        step();
        start = 1'b0;
        fetch_words();
        step();                      // now in WAIT, cycle 0
        data_received = 1'b1;
        for (int i = 0; i < c_TIMEOUT; i++) begin
            #1;
            if (i == 0) chk("wd_wait_shift", ahb_shift_en, c_PF_EXP);
            if (i == c_TIMEOUT - 1) chk("wd_not_yet", error, 0);
            step();
        end
        chk("wd_error", error, 1);
        chk("wd_busy", busy, 0);
        chk("wd_shift", ahb_shift_en, 0);
        data_received = 1'b0;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        #1;
        chk("wd_clr_error", error, 0);
        chk("wd_clr_busy", busy, 0);

        // ---- 5: reset in the middle of WRITE ----
        start = 1'b1; data_type = 1'b0; enc_dec = 1'b1;
        step();
        start = 1'b0;
        fetch_words();
        step();
        enc_done = 1'b1;
        step();
        enc_done = 1'b0;
        tx_ready = 1'b1;
        step(); step();
        chk("rst_mid_idx", word_idx, 2);
        chk("rst_mid_opt", opt_mode, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        tx_ready = 1'b0;
        #1;
        chk_all_zero("rst_mid");

`ifdef AES_CTRL_PREFETCH_EN
        // ---- 6: prefetch a full block in WAIT, skip FETCH ----
        start = 1'b1; data_type = 1'b0; enc_dec = 1'b0;
        step();
        fetch_words();
        step();                      // WAIT
        data_received = 1'b1;
        repeat (c_WORDS) step();
        chk("pf_full_stall", ahb_shift_en, 0);
        data_received = 1'b0;
        enc_done = 1'b1;
        step();
        enc_done = 1'b0;
        tx_ready = 1'b1;
        repeat (c_WORDS) step();
        tx_ready = 1'b0;
        #1;
        chk("pf_direct_enc", aes_enable, 1);
        chk("pf_idx", word_idx, 0);
        step();
        start = 1'b0;
        enc_done = 1'b1;
        step();
        enc_done = 1'b0;
        tx_ready = 1'b1;
        repeat (c_WORDS) step();
        tx_ready = 1'b0;
        #1;
        chk("pf_end_idle", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Third CHG_KEY cycle: completion pulse, then back in IDLE.
    task automatic chk_key_done_phase();
        chk("key_load_c3", load_key, 1);
        chg_key_done = 1'b1;
        #1;
        chk("key_done_pulse", done_chg_key, 1);
        step();
        chg_key_done = 1'b0;
        #1;
        chk("key_done_single", done_chg_key, 0);
        chk("key_load_off", load_key, 0);
        chk("key_idle_busy", busy, 0);
    endtask

endmodule
`default_nettype wire
